// File: rtl/uart_rx_fifo.sv
`default_nettype none
// =====================================================================
// Module   : uart_rx_fifo
// Brief    : 16x-oversampled UART receiver with parity and framing checks
//            feeding a first-word-fall-through receive buffer.
// Revision : 1.0 - initial release
// =====================================================================
module uart_rx_fifo #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    output logic                        led
);
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_BIT_W = $clog2(DATA_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [c_DIV_W-1:0]   r_div;
    logic [2:0]           r_state;
    logic [3:0]           r_tick;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_wr_req;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overflow;
    logic                 r_led;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic w_tick;
    logic w_mid;
    logic w_par_bad;
    logic w_full;
    logic w_pop;
    logic w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Divider is held in IDLE so every frame starts with the same tick phase
    always_ff @(posedge clk) begin
        if (rst || r_state == c_IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign w_tick = (r_state != c_IDLE) && (r_div == c_DIV_LAST);
    assign w_mid  = w_tick && (r_tick == 4'd15);

    generate
        if (PARITY == 0) begin : g_no_par
            assign w_par_bad = 1'b0;
        end else if (PARITY == 1) begin : g_even_par
            assign w_par_bad = ^{r_shift, r_par_bit};
        end else begin : g_odd_par
            assign w_par_bad = ~(^{r_shift, r_par_bit});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_wr_req     <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_req     <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= c_START;
                        r_tick  <= '0;
                    end
                end
                c_START: begin
                    // Eighth tick is mid start bit; restarting the count here puts later samples mid-bit
                    if (w_tick) begin
                        if (r_tick == 4'd7) begin
                            r_tick  <= '0;
                            r_bit   <= '0;
                            r_state <= r_rx_sync ? c_IDLE : c_DATA;
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_tick <= r_tick + 4'd1;
                    end
                    if (w_mid) begin
                        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + c_BIT_W'(1);
                        if (r_bit == c_BIT_LAST) begin
                            r_state <= (PARITY == 0) ? c_STOP : c_PAR;
                        end
                    end
                end
                c_PAR: begin
                    if (w_tick) begin
                        r_tick <= r_tick + 4'd1;
                    end
                    if (w_mid) begin
                        r_par_bit <= r_rx_sync;
                        r_state   <= c_STOP;
                    end
                end
                c_STOP: begin
                    if (w_tick) begin
                        r_tick <= r_tick + 4'd1;
                    end
                    if (w_mid) begin
                        r_state <= c_IDLE;
                        if (!r_rx_sync) begin
                            r_frame_err <= 1'b1;
                        end else if (w_par_bad) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_wr_req <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // The received byte stays in r_shift until the next frame's data phase
    assign w_full = (r_count == c_FULL);
    assign w_pop  = m_valid && m_ready;
    assign w_push = r_wr_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_overflow <= r_wr_req && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
                r_led           <= ~r_led;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    assign m_data     = r_mem[r_rd_ptr];
    assign m_valid    = (r_count != '0);
    assign fifo_count = r_count;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign led        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// =====================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_uart_rx_fifo;
    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int PARITY     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int c_BIT_CLKS = 16 * CLK_DIV;
    localparam int c_FRAME    = 11 * c_BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       led;

    int passed = 0;
    int total = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf = 0;

    logic [7:0] q[$];
    logic       exp_led = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst), .rx(rx),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow), .led(led)
    );

    // Cycles each flag spends high; a clean single pulse adds exactly one
    always @(negedge clk) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed run still active, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/count"}, fifo_count, q.size());
        chk({tag, "/valid"}, m_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, "/data"}, m_data, q[0]);
        chk({tag, "/led"}, led, exp_led);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/count"}, fifo_count, 0);
        chk({tag, "/valid"}, m_valid, 0);
        chk({tag, "/data"}, m_data, 0);
        chk({tag, "/flags"}, {parity_err, frame_err, overflow}, 0);
        chk({tag, "/led"}, led, 0);
    endtask

    // Frame = start, data LSB first, even parity (optionally inverted), stop
    task automatic send_bits(input logic [7:0] d, input logic par_flip, input logic stop,
                             input int ncyc);
        logic [10:0] f;
        f = {stop, (^d) ^ par_flip, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            rx = f[c / c_BIT_CLKS];
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop,
                         input string tag);
        int   p0, f0, o0;
        logic e_f, e_p, e_o, push;
        p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
        send_bits(d, par_flip, stop, c_FRAME);
        // A low stop bit looks like a new start edge; idle long enough for it to be rejected
        if (!stop) repeat (2 * c_BIT_CLKS) @(negedge clk);
        e_f  = !stop;
        e_p  = stop && par_flip;
        push = stop && !par_flip;
        e_o  = push && (q.size() == FIFO_DEPTH);
        if (push && !e_o) begin
            q.push_back(d);
            exp_led = ~exp_led;
        end
        chk({tag, "/frame_err"}, n_ferr - f0, e_f);
        chk({tag, "/parity_err"}, n_perr - p0, e_p);
        chk({tag, "/overflow"}, n_ovf - o0, e_o);
        check_state(tag);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        e = q.pop_front();
        chk({tag, "/pop_valid"}, m_valid, 1);
        chk({tag, "/pop_data"}, m_data, e);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_state(tag);
    endtask

    initial begin
        int p0, f0, o0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Short low glitch on the line must be rejected silently
        p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (3 * c_BIT_CLKS) @(negedge clk);
        chk("glitch/flags", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);
        check_state("glitch");

        frame(8'h55, 1'b0, 1'b1, "good55");
        pop_one("pop55");

        frame(8'h55, 1'b1, 1'b1, "par_bad");
        frame(8'hA3, 1'b1, 1'b0, "stop_bad");

        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b1, $sformatf("fill%0d", i));
        for (int i = 0; i < 4; i++) pop_one($sformatf("drain%0d", i));

        for (int i = 1; i <= 4; i++) frame(8'(i), 1'b0, 1'b1, $sformatf("refill%0d", i));
        // Pop lands on the write cycle of the fifth byte while full
        o0 = n_ovf;
        fork
            send_bits(8'h05, 1'b0, 1'b1, c_FRAME);
            begin
                repeat (675) @(posedge clk);
                @(negedge clk);
                m_ready = 1'b1;
                @(negedge clk);
                m_ready = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h05);
        exp_led = ~exp_led;
        chk("full_pop/overflow", n_ovf - o0, 0);
        check_state("full_pop");
        for (int i = 0; i < 4; i++) pop_one($sformatf("full_drain%0d", i));

        // Randomized back-to-back frames with occasional errors and pops
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            int         kind;
            d    = 8'($urandom);
            kind = $urandom_range(0, 5);
            frame(d, kind == 4, kind != 5, $sformatf("rnd%0d", i));
            if (q.size() != 0 && $urandom_range(0, 2) == 0) pop_one($sformatf("rnd_pop%0d", i));
        end
        if (q.size() == 0) frame(8'h99, 1'b0, 1'b1, "pre_rst");

        // Reset mid-frame, with a pop requested in the same cycles
        send_bits(8'h3C, 1'b0, 1'b1, 300);
        rst     = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        exp_led = 1'b0;
        check_reset("mid_rst");
        m_ready = 1'b0;
        rst     = 1'b0;
        repeat (4) @(negedge clk);
        frame(8'h3C, 1'b0, 1'b1, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per oversample tick (>=1).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port m_data, output, DATA_BITS, oldest buffered byte.
REQ-009 SHALL have port m_valid, output, 1, buffer non-empty.
REQ-010 SHALL have port m_ready, input, 1, consumer accepts m_data.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, entries held.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on stop bit sampled low.
REQ-014 SHALL have port overflow, output, 1, one-cycle pulse when a good byte is dropped (buffer full).
REQ-015 SHALL have port led, output, 1, toggles on every byte written into buffer.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL generate an oversample tick once every CLK_DIV clk cycles; 16 ticks = 1 bit period.
REQ-018 SHALL implement states IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY=0.
REQ-019 IDLE -> START on synchronized rx falling to 0; tick counter cleared.
REQ-020 START: at tick 8 if rx=1 SHALL return to IDLE (glitch rejected, no flags); if rx=0 proceed to DATA, re-aligned so subsequent samples occur at mid-bit (every 16 ticks).
REQ-021 DATA: SHALL sample DATA_BITS bits LSB first, one per bit period; then PAR or STOP.
REQ-022 PAR: SHALL sample one bit; even mode expects XOR(data,par)=0, odd mode expects 1.
REQ-023 STOP: at mid-bit sample; state returns to IDLE the next cycle regardless of result.
REQ-024 Stop bit 0 SHALL pulse frame_err, byte discarded; frame_err takes priority over parity_err (only frame_err pulses).
REQ-025 Parity mismatch with valid stop SHALL pulse parity_err, byte discarded.
REQ-026 Good byte SHALL be written to buffer on the cycle after stop-bit sample; m_valid high one cycle after write when buffer was empty.
REQ-027 Buffer SHALL be first-word-fall-through: m_data = head whenever m_valid=1; m_data undefined-but-stable (hold last) when empty.
REQ-028 Pop occurs on cycle m_valid && m_ready; m_ready while empty SHALL have no effect.
REQ-029 Simultaneous write and pop SHALL keep fifo_count unchanged; when full, simultaneous pop SHALL allow the write (no overflow).
REQ-030 Write when full without pop SHALL pulse overflow; contents and count unchanged.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-032 A new start bit SHALL be accepted in IDLE immediately after STOP (back-to-back frames, no gap required).

Reset
REQ-033 rst SHALL force state IDLE, counters 0, pointers 0, fifo_count 0, m_valid 0, m_data 0, parity_err/frame_err/overflow 0, led 0, synchronizer flops 1.
REQ-034 rst mid-frame SHALL abandon the frame with no flags and no write; rst overrides any same-cycle write or pop.

Verification (CLK_DIV=4, DATA_BITS=8, PARITY=1, FIFO_DEPTH=4; bit = 64 clk)
REQ-035 Frame 0x55, parity 0, stop 1, m_ready=0 -> m_valid=1, m_data=0x55, fifo_count=1, led=1, no error pulses.
REQ-036 rx low for 16 clk then high -> state back to IDLE, no flags, fifo_count 0.
REQ-037 Frame 0x55 with parity 1 -> parity_err single pulse, fifo_count unchanged; frame 0xA3 with stop 0 -> frame_err single pulse, parity_err 0.
REQ-038 Five frames 0x01..0x05, m_ready=0 -> fifo_count=4, overflow pulse on 5th, then m_ready=1 pops 0x01,0x02,0x03,0x04 in order, m_valid falls after 4th.
REQ-039 Buffer full, m_ready=1 held during 5th frame write cycle -> no overflow, fifo_count stays 4, last entry 0x05.
REQ-040 rst asserted mid-DATA of frame 0x3C -> all outputs at reset values, next clean frame 0x3C received correctly.
